// File: rtl/rainbow_pkg.sv
// Shared types and the segment-to-duty mapping for the rainbow colour-wheel PWM.
package rainbow_pkg;

    localparam int SEGMENTS = 6;

    typedef enum logic {
        MODE_SMOOTH  = 1'b0,
        MODE_STEPPED = 1'b1
    } mode_t;

    // Duty is produced at 16 bits so one helper serves every PWM_BITS up to 16.
    function automatic logic [15:0] seg_duty(input logic [2:0]  seg,
                                             input logic [15:0] frac,
                                             input logic [15:0] dmax,
                                             input mode_t       mode);
        logic [15:0] d;
        d = 16'd0;
        if (mode == MODE_STEPPED) begin
            d = (seg < 3'd3) ? dmax : 16'd0;
        end else begin
            case (seg)
                3'd0:       d = frac;
                3'd1, 3'd2: d = dmax;
                3'd3:       d = dmax - frac;
                default:    d = 16'd0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rainbow_pwm_if.sv
// Control and LED-drive bundle between the board top level and rainbow_pwm.
interface rainbow_pwm_if #(
    parameter int NUM_CH = 3
);
    logic              en;
    logic              mode;
    logic [NUM_CH-1:0] led_out;
    logic              wrap;

    modport master (output en, output mode, input led_out, input wrap);
    modport slave  (input en, input mode, output led_out, output wrap);
endinterface

// File: rtl/pwm_channel.sv
// One colour channel: duty staging register, frame-aligned active duty and PWM compare.
module pwm_channel
    import rainbow_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                frame_end,
    output logic                led
);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_act;

    // duty_act only moves at the frame boundary so a frame never mixes two duties.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q   <= '0;
            duty_act <= '0;
            led      <= 1'b0;
        end else begin
            duty_q <= duty;
            if (frame_end) begin
                duty_act <= duty_q;
            end
            led <= (duty_act > pwm_cnt);
        end
    end

endmodule

// File: rtl/rainbow_pwm.sv
// Phase-offset colour-wheel PWM generator; the board maps led_out[0..2] to RGB_G, RGB_B, RGB_R.
module rainbow_pwm
    import rainbow_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 46875,
    parameter int NUM_CH      = 3
) (
    input logic               clk,
    input logic               rst,
    rainbow_pwm_if.slave      bus
);

    localparam int TOTAL = SEGMENTS * (1 << PWM_BITS);
    localparam int POS_W = $clog2(TOTAL);
    localparam int OFF   = TOTAL / NUM_CH;
    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [PWM_BITS-1:0] DMAX     = '1;
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(TOTAL - 1);
    localparam logic [POS_W:0]      TOTAL_X  = (POS_W + 1)'(TOTAL);

    logic [TMR_W-1:0]    step_tmr;
    logic [POS_W-1:0]    pos;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap_q;
    logic                frame_end;
    logic [NUM_CH-1:0]   led_vec;

    assign frame_end = (pwm_cnt == DMAX);

    // pwm_cnt is never gated by en so a frozen hue still shows its colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_tmr <= '0;
            pos      <= '0;
            pwm_cnt  <= '0;
            wrap_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            wrap_q  <= 1'b0;
            if (bus.en) begin
                if (step_tmr == TMR_LAST) begin
                    step_tmr <= '0;
                    if (pos == POS_LAST) begin
                        pos    <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end else begin
                    step_tmr <= step_tmr + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [POS_W:0]      hue_sum;
        logic [POS_W:0]      hue_x;
        logic [POS_W-1:0]    hue;
        logic [2:0]          seg;
        logic [PWM_BITS-1:0] frac;
        logic [PWM_BITS-1:0] duty;

        // TOTAL is not a power of two, so wrap with a compare-and-subtract.
        assign hue_sum = {1'b0, pos} + (POS_W + 1)'(c * OFF);
        assign hue_x   = (hue_sum >= TOTAL_X) ? (hue_sum - TOTAL_X) : hue_sum;
        assign hue     = hue_x[POS_W-1:0];
        assign seg     = hue[POS_W-1:PWM_BITS];
        assign frac    = hue[PWM_BITS-1:0];
        assign duty    = PWM_BITS'(seg_duty(seg, 16'(frac), 16'(DMAX), mode_t'(bus.mode)));

        pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .duty     (duty),
            .pwm_cnt  (pwm_cnt),
            .frame_end(frame_end),
            .led      (led_vec[c])
        );
    end

    assign bus.led_out = led_vec;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_rainbow_pwm.sv
// Bench for rainbow_pwm at PWM_BITS=2, STEP_CYCLES=2 with 3- and 6-channel instances.
module tb_rainbow_pwm;

    localparam int PB    = 2;
    localparam int STEP  = 2;
    localparam int DMAX  = (1 << PB) - 1;
    localparam int TOTAL = 6 * (1 << PB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic mode = 1'b0;

    always #5 clk = ~clk;

    rainbow_pwm_if #(.NUM_CH(3)) bus3 ();
    rainbow_pwm_if #(.NUM_CH(6)) bus6 ();

    assign bus3.en   = en;
    assign bus3.mode = mode;
    assign bus6.en   = en;
    assign bus6.mode = mode;

    rainbow_pwm #(.PWM_BITS(PB), .STEP_CYCLES(STEP), .NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave));
    rainbow_pwm #(.PWM_BITS(PB), .STEP_CYCLES(STEP), .NUM_CH(6)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pos, m_tmr, m_pwm;
    int m_wrap;
    int dq [2][6];
    int da [2][6];
    int ld [2][6];
    int nch [2] = '{3, 6};
    int wraps_seen;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_duty(input int pos, input int c, input int n, input int md);
        int hue, seg, frac;
        hue  = (pos + c * (TOTAL / n)) % TOTAL;
        seg  = hue / (DMAX + 1);
        frac = hue % (DMAX + 1);
        if (md != 0) return (seg < 3) ? DMAX : 0;
        case (seg)
            0:       return frac;
            1, 2:    return DMAX;
            3:       return DMAX - frac;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input int r, input int e, input int md);
        if (r != 0) begin
            m_pos = 0; m_tmr = 0; m_pwm = 0; m_wrap = 0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 6; c++) begin
                    dq[k][c] = 0; da[k][c] = 0; ld[k][c] = 0;
                end
        end else begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < nch[k]; c++) begin
                    ld[k][c] = (da[k][c] > m_pwm) ? 1 : 0;
                    if (m_pwm == DMAX) da[k][c] = dq[k][c];
                    dq[k][c] = ref_duty(m_pos, c, nch[k], md);
                end
            m_pwm  = (m_pwm + 1) % (DMAX + 1);
            m_wrap = 0;
            if (e != 0) begin
                if (m_tmr + 1 == STEP) begin
                    m_tmr = 0;
                    m_pos = (m_pos + 1) % TOTAL;
                    m_wrap = (m_pos == 0) ? 1 : 0;
                end else begin
                    m_tmr = m_tmr + 1;
                end
            end
        end
    endtask

    function automatic int exp_leds(input int k);
        int v;
        v = 0;
        for (int c = 0; c < nch[k]; c++) v |= ld[k][c] << c;
        return v;
    endfunction

    task automatic tick();
        int r, e, md;
        r = rst; e = en; md = mode;
        @(posedge clk);
        model_edge(r, e, md);
        #1;
        check("led_out3", int'(bus3.led_out), exp_leds(0));
        check("led_out6", int'(bus6.led_out), exp_leds(1));
        check("wrap3", int'(bus3.wrap), m_wrap);
        check("wrap6", int'(bus6.wrap), m_wrap);
        if (bus3.wrap) wraps_seen++;
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit mode;
        int cycles;
        int exp_pos;
        int exp_wraps;
    } phase_t;

    phase_t tbl [10];

    initial begin
        int ones1, ones02;

        tbl[0] = '{1'b1, 1'b0, 1'b0,  3,  0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b0,  4,  0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 10,  5, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 20,  5, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b0,  2,  6, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16, 14, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b0,  6, 17, 0};
        tbl[7] = '{1'b1, 1'b1, 1'b0,  1,  0, 0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 48,  0, 1};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 20, 10, 0};

        model_edge(1, 0, 0);

        // Reset, then a frozen hue at pos 0: only channel 1 lights, 3 of every 4 cycles.
        rst = 1'b1; en = 1'b0; mode = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        ones1 = 0; ones02 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ones1  += int'(bus3.led_out[1]);
            ones02 += int'(bus3.led_out[0]) + int'(bus3.led_out[2]);
        end
        check("ch1_on_count", ones1, 6);
        check("ch0_ch2_off", ones02, 0);

        for (int p = 0; p < 10; p++) begin
            rst = tbl[p].rst; en = tbl[p].en; mode = tbl[p].mode;
            wraps_seen = 0;
            for (int i = 0; i < tbl[p].cycles; i++) tick();
            check($sformatf("pos3_phase%0d", p), int'(dut3.pos), tbl[p].exp_pos);
            check($sformatf("pos6_phase%0d", p), int'(dut6.pos), tbl[p].exp_pos);
            check($sformatf("wraps_phase%0d", p), wraps_seen, tbl[p].exp_wraps);
        end

        // Randomised run with occasional resets and mode changes.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            tick();
            if (i % 50 == 49) check("pos_rand", int'(dut3.pos), m_pos);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rainbow_pwm.md
Name: rainbow_pwm

Overview:
- Parametrised successor to the fixed 3-tap shift-register colour cycler.
- Generates NUM_CH phase-offset colour-wheel channels. Each channel has a smooth (PWM-faded) or stepped (hard on/off) profile, a programmable hue step rate and an enable/freeze control.
- Sits between the top-level clock and the RGB LED pins. Replaces the direct flop-per-colour drive.
- The top level maps led_out[0..2] to RGB_G, RGB_B and RGB_R.

Parameters:
- PWM_BITS, 8: duty and PWM counter width. Duty max is DMAX = 2^PWM_BITS-1.
- STEP_CYCLES, 46875: clock cycles per hue position step. Must be ≥1.
- NUM_CH, 3: output channel count. Must be in {1,2,3,6}.
- Derived: TOTAL = 6·2^PWM_BITS hue positions; OFF = TOTAL/NUM_CH per-channel hue offset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = hue advances; 0 = hue frozen, PWM keeps running.
- mode  in  1  0 = smooth fade, 1 = stepped.
- led_out  out  NUM_CH  PWM drive per channel, registered.
- wrap  out  1  one-cycle pulse when the hue position wraps TOTAL-1 -> 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - step_tmr, pos, pwm_cnt, duty_q and duty_act all become 0.
  - led_out = 0 and wrap = 0.
  - rst asserted mid-operation aborts the cycle cleanly. There is no partial state.
- Step timer:
  - When en=1, step_tmr counts 0..STEP_CYCLES-1.
  - At terminal count it returns to 0 and pos increments.
  - When en=0, step_tmr and pos hold their values.
- pos wrap:
  - pos = TOTAL-1 with an increment gives pos = 0, and wrap = 1 for exactly that one cycle.
  - wrap is registered, high in the cycle after the edge that zeroes pos.
- Per-channel hue:
  - hue_c = (pos + c·OFF) mod TOTAL.
  - seg = hue_c >> PWM_BITS, range 0..5.
  - frac = hue_c[PWM_BITS-1:0].
- Duty, smooth mode (mode=0), by segment:
  - seg 0: frac
  - seg 1 and 2: DMAX
  - seg 3: DMAX-frac
  - seg 4 and 5: 0
- Duty, stepped mode (mode=1):
  - DMAX for seg 0, 1, 2; 0 for seg 3, 4, 5.
  - This gives a 3-on/3-off ring, which is the legacy behaviour at NUM_CH=3.
- Duty pipeline:
  - duty_q[c] is registered from combinational duty every cycle.
  - pwm_cnt free-runs 0..DMAX and wraps. It is not gated by en.
  - duty_act[c] <= duty_q[c] only on the edge where pwm_cnt == DMAX. This makes updates glitch-free and aligned to PWM frame boundaries.
  - A mode change mid-frame takes effect at the next frame boundary.
- Output:
  - led_out[c] <= (duty_act[c] > pwm_cnt), registered.
  - Duty 0 gives a constant 0. Duty DMAX gives high for DMAX of every 2^PWM_BITS cycles.
- Latency from a pos change to a visible led_out change: 1 cycle to duty_q, then up to 2^PWM_BITS cycles to the frame boundary, then 1 cycle to led_out.
- Arithmetic: pos has width clog2(TOTAL). Offset addition uses one extra bit, then a conditional subtract of TOTAL. No wrap relies on a power of two, because TOTAL is 6·2^N.
- Simultaneous events: en falling on a terminal-count edge means the step still does not occur (en is sampled on that edge). rst has priority over everything.

Decomposition:
- Package rainbow_pkg:
  - SEGMENTS = 6.
  - typedef enum mode_t {MODE_SMOOTH, MODE_STEPPED}.
  - function seg_duty(seg, frac, mode) returning the duty.
- Sub-module pwm_channel:
  - One instance per channel.
  - Holds duty_q and duty_act, and does the compare.
  - Inputs: clk, rst, duty, pwm_cnt, frame_end. Output: led.
- Timer, pos, pwm_cnt and wrap live in rainbow_pwm.

Test Plan:
All scenarios use PWM_BITS=2 and STEP_CYCLES=2, so TOTAL=24, OFF=8 and DMAX=3, unless stated otherwise.
1. Reset: rst high for 3 cycles, then release with en=0 -> led_out=000 and wrap=0 throughout reset. After release:
   - duty0=0, duty1=3 (hue 8, seg 2), duty2=0 (hue 16, seg 4).
   - After the first frame boundary, led_out[1] is high 3 of every 4 cycles; led_out[0] and led_out[2] stay 0.
2. Stepping:
   - en=1, mode=0 -> pos increments every 2 cycles.
   - At pos=1, duty0=1, so led_out[0] is high 1 cycle per 4.
   - At pos=14 (ch0 seg 3, frac 2), duty0=1.
3. Wrap: run 48 cycles from reset with en=1 -> pos returns to 0 and wrap pulses exactly once, for 1 cycle.
4. Freeze: drop en at pos=5 for 20 cycles -> pos stays 5, PWM pattern unchanged, no wrap. Resume -> pos=6 two cycles later.
5. Stepped mode: mode=1 at pos=0 -> after the frame boundary:
   - ch0 = DMAX, ch1 = DMAX (seg 2), ch2 = 0.
   - As pos sweeps, each channel is on for 12 consecutive positions.
6. Mid-run reset and NUM_CH=6: assert rst at pos=17 -> next cycle all state is 0 and led_out=0. Repeat with NUM_CH=6 (OFF=4) -> six channels with duties staggered one segment apart.
